// File: rtl/gpio_in_cond.sv
// rtl/gpio_in_cond.sv - GPIO pad input conditioning: sync, optional debounce, edge IRQ, WB regs
// Define GPIO_IN_DEBOUNCE_EN to add the per-pin debounce counters.
module gpio_in_cond #(
  parameter int NO_OF_GPIO_PINS = 24,
  parameter int DB_CYCLES       = 16
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic [NO_OF_GPIO_PINS-1:0] pad_gpio_i,
  output logic [NO_OF_GPIO_PINS-1:0] gpio_o,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_we_i,
  input  logic [3:0]                 wb_adr_i,
  input  logic [3:0]                 wb_sel_i,
  input  logic [31:0]                wb_dat_i,
  output logic [31:0]                wb_dat_o,
  output logic                       wb_ack_o,
  output logic                       irq_o
);

  localparam int N    = NO_OF_GPIO_PINS;
  localparam int DB_W = $clog2(DB_CYCLES) + 1;

  logic [N-1:0] s1, s2, stable, stable_d;
  logic [N-1:0] rise_en, fall_en, pending;
  logic [N-1:0] lane_mask, wr_data, w1c, rise, fall;
  logic [1:0]   reg_sel;
  logic         wb_wr;
  logic [31:0]  rdata;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pad_gpio_i;
      s2 <= s1;
    end
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  logic [DB_W-1:0] cnt [N];

  // A change is accepted only after DB_CYCLES consecutive samples differ from stable.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stable <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + DB_W'(1);
        end
      end
    end
  end
`else
  localparam int unused_db_w = DB_W;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) stable <= '0;
    else          stable <= s2;
  end
`endif

  assign gpio_o   = stable;
  assign rise     = stable & ~stable_d;
  assign fall     = ~stable & stable_d;
  assign irq_o    = |pending;
  assign wb_ack_o = wb_cyc_i & wb_stb_i;
  assign wb_wr    = wb_cyc_i & wb_stb_i & wb_we_i;
  assign reg_sel  = wb_adr_i[3:2];
  assign wr_data  = wb_dat_i[N-1:0];

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < N; i++) lane_mask[i] = wb_sel_i[i/8];
  end

  assign w1c = (wb_wr && reg_sel == 2'd2) ? (wr_data & lane_mask) : '0;

  // Set terms are OR'd after the clear so a same-cycle edge wins over W1C.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stable_d <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      pending  <= '0;
    end else begin
      stable_d <= stable;
      pending  <= (pending & ~w1c) | (rise & rise_en) | (fall & fall_en);
      if (wb_wr && reg_sel == 2'd0) rise_en <= (rise_en & ~lane_mask) | (wr_data & lane_mask);
      if (wb_wr && reg_sel == 2'd1) fall_en <= (fall_en & ~lane_mask) | (wr_data & lane_mask);
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0:    rdata[N-1:0] = rise_en;
      2'd1:    rdata[N-1:0] = fall_en;
      2'd2:    rdata[N-1:0] = pending;
      default: rdata[N-1:0] = stable;
    endcase
  end

  assign wb_dat_o = rdata;

  logic unused_bits;
  assign unused_bits = &{1'b0, wb_adr_i[1:0], wb_dat_i, wb_sel_i};

endmodule

// File: tb/tb_gpio_in_cond.sv
// tb/tb_gpio_in_cond.sv - directed-vector bench for gpio_in_cond (either GPIO_IN_DEBOUNCE_EN build)
module tb_gpio_in_cond;

  localparam int N  = 24;
  localparam int DB = 16;
`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int LAT = 2 + DB;
`else
  localparam int LAT = 3;
`endif

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic [N-1:0]  pad_gpio_i;
  logic [N-1:0]  gpio_o;
  logic          wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]    wb_adr_i, wb_sel_i;
  logic [31:0]   wb_dat_i, wb_dat_o;
  logic          wb_ack_o, irq_o;

  int n_vec = 0;
  int n_bad = 0;
  logic seen;

  gpio_in_cond #(.NO_OF_GPIO_PINS(N), .DB_CYCLES(DB)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .pad_gpio_i(pad_gpio_i), .gpio_o(gpio_o),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .irq_o(irq_o)
  );

  always #10 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] idx, input logic [31:0] exp);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = {idx, 2'b00};
    #1;
    chk({tag, "_ack"}, {31'd0, wb_ack_o}, 32'd1);
    chk(tag, wb_dat_o, exp);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    #1;
  endtask

  task automatic wb_write(input logic [1:0] idx, input logic [31:0] dat, input logic [3:0] sel);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = {idx, 2'b00}; wb_dat_i = dat; wb_sel_i = sel;
    @(posedge wb_clk_i);
    #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  initial begin
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0; wb_sel_i = 0; wb_dat_i = 0;

    // T1 reset with all pads high
    wb_rst_i = 1'b1;
    pad_gpio_i = 24'hFFFFFF;
    tick(2);
    chk("rst_gpio", 32'(gpio_o), 32'h0);
    chk("rst_irq", {31'd0, irq_o}, 32'h0);
    rd_chk("rst_rise_en", 2'd0, 32'h0);
    rd_chk("rst_fall_en", 2'd1, 32'h0);
    rd_chk("rst_pending", 2'd2, 32'h0);
    rd_chk("rst_status", 2'd3, 32'h0);
    wb_rst_i = 1'b0;
    tick(LAT - 1);
    chk("post_rst_gpio_early", 32'(gpio_o), 32'h0);
    tick(1);
    chk("post_rst_gpio", 32'(gpio_o), 32'hFFFFFF);
    tick(1);
    rd_chk("post_rst_no_pend", 2'd2, 32'h0);
    chk("post_rst_irq", {31'd0, irq_o}, 32'h0);
    pad_gpio_i = '0;
    tick(LAT + 2);
    chk("pads_low_gpio", 32'(gpio_o), 32'h0);
    rd_chk("pads_low_pend", 2'd2, 32'h0);

    // T2 rise interrupt on pin 0
    wb_write(2'd0, 32'h1, 4'hF);
    pad_gpio_i[0] = 1'b1;
    tick(LAT - 1);
    chk("t2_gpio_early", {31'd0, gpio_o[0]}, 32'h0);
    tick(1);
    chk("t2_gpio", {31'd0, gpio_o[0]}, 32'h1);
    chk("t2_irq_early", {31'd0, irq_o}, 32'h0);
    tick(1);
    chk("t2_irq", {31'd0, irq_o}, 32'h1);
    rd_chk("t2_pending", 2'd2, 32'h1);
    wb_write(2'd2, 32'h1, 4'hF);
    chk("t2_irq_clr", {31'd0, irq_o}, 32'h0);
    rd_chk("t2_pending_clr", 2'd2, 32'h0);

    // T3 15-cycle pulse on pin 3 with FALL_EN[3]
    wb_write(2'd1, 32'h8, 4'hF);
    seen = 1'b0;
    pad_gpio_i[3] = 1'b1;
    repeat (15) begin tick(1); seen |= gpio_o[3]; end
    pad_gpio_i[3] = 1'b0;
    repeat (LAT + 6) begin tick(1); seen |= gpio_o[3]; end
`ifdef GPIO_IN_DEBOUNCE_EN
    chk("t3_glitch_seen", {31'd0, seen}, 32'h0);
    rd_chk("t3_glitch_pend", 2'd2, 32'h0);
    seen = 1'b0;
    pad_gpio_i[3] = 1'b1;
    repeat (16) begin tick(1); seen |= gpio_o[3]; end
    pad_gpio_i[3] = 1'b0;
    repeat (LAT + 6) begin tick(1); seen |= gpio_o[3]; end
    chk("t3_16cyc_seen", {31'd0, seen}, 32'h1);
`else
    chk("t3_pulse_seen", {31'd0, seen}, 32'h1);
`endif
    rd_chk("t3_fall_pend", 2'd2, 32'h8);
    chk("t3_irq", {31'd0, irq_o}, 32'h1);
    wb_write(2'd2, 32'h8, 4'hF);
    rd_chk("t3_pend_clr", 2'd2, 32'h0);
    wb_write(2'd1, 32'h0, 4'hF);

    // T4 rise on pin 5 in the same cycle as W1C of bit 5
    wb_write(2'd0, 32'h21, 4'hF);
    pad_gpio_i[5] = 1'b1;
    tick(LAT);
    wb_write(2'd2, 32'h20, 4'hF);
    chk("t4_irq", {31'd0, irq_o}, 32'h1);
    rd_chk("t4_set_wins", 2'd2, 32'h20);
    wb_write(2'd0, 32'h0, 4'hF);
    rd_chk("t4_disable_keeps", 2'd2, 32'h20);
    wb_write(2'd2, 32'h20, 4'b1110);
    rd_chk("t4_w1c_sel0", 2'd2, 32'h20);
    wb_write(2'd2, 32'h20, 4'b0001);
    rd_chk("t4_w1c", 2'd2, 32'h0);
    chk("t4_irq_clr", {31'd0, irq_o}, 32'h0);

    // T5 byte lanes, zero extension, STATUS read-only
    rd_chk("t5_rise_en_zero", 2'd0, 32'h0);
    wb_write(2'd0, 32'h00AABBCC, 4'b0010);
    rd_chk("t5_lane1", 2'd0, 32'h0000BB00);
    wb_write(2'd1, 32'hFFFFFFFF, 4'hF);
    rd_chk("t5_zero_ext", 2'd1, 32'h00FFFFFF);
    wb_write(2'd1, 32'h00123456, 4'b0101);
    rd_chk("t5_lanes02", 2'd1, 32'h0012FF56);
    wb_write(2'd3, 32'hFFFFFFFF, 4'hF);
    rd_chk("t5_status", 2'd3, 32'h21);
    chk("t5_gpio", 32'(gpio_o), 32'h21);
    wb_write(2'd1, 32'h0, 4'hF);
    rd_chk("t5_pend", 2'd2, 32'h0);

    // T6 reset partway through a pin 1 debounce
    pad_gpio_i[1] = 1'b1;
    tick(10);
    wb_rst_i = 1'b1;
    tick(1);
    chk("t6_rst_gpio", 32'(gpio_o), 32'h0);
    rd_chk("t6_rst_rise_en", 2'd0, 32'h0);
    wb_rst_i = 1'b0;
    tick(LAT - 1);
    chk("t6_gpio_early", 32'(gpio_o), 32'h0);
    tick(1);
    chk("t6_gpio", 32'(gpio_o), 32'h23);
    tick(1);
    rd_chk("t6_pend", 2'd2, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
